// File: rtl/rom_msg_pkg.sv
// Shared types and constants for the message ROM reader.
// Holds width defaults, the reader state enum and the ROM image.
package rom_msg_pkg;

    localparam int ROM_ADDR_W = 4;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    // "I love you dude!" as stored in the 16x8 ROM
    localparam logic [7:0] ROM_MSG [0:15] = '{
        8'h49, 8'h20, 8'h6C, 8'h6F,
        8'h76, 8'h65, 8'h20, 8'h79,
        8'h6F, 8'h75, 8'h20, 8'h64,
        8'h75, 8'h64, 8'h65, 8'h21
    };

endpackage

// File: rtl/rom_msg_if.sv
// Byte stream valid/ready bundle with last-byte flag.
// master drives m_data/m_valid/m_last, slave drives m_ready.
interface rom_msg_if #(
    parameter int DATA_W = 8
);

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/rom_msg_reader_byte_fifo.sv
// DEPTH-entry synchronous FIFO of {last, data} with occupancy count.
// Ports: push/push_data/push_last in, pop in, head_data/head_last/count out.
module byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic [CW-1:0]     count
);

    localparam int PW = $clog2(DEPTH);

    typedef logic [DATA_W:0] entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = {push_last, push_data};
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // Storage is cleared too so the head reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign {head_last, head_data} = mem_q[rd_q];
    assign count                  = cnt_q;

endmodule

// File: rtl/rom_msg_reader.sv
// Walks a ROM message window and re-emits it as a valid/ready byte stream.
// Ports: start/start_addr/msg_len in, rom_addr/rom_en out, rom_data in,
// m (stream master), busy/done status out.
module rom_msg_reader
    import rom_msg_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   msg_len,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    rom_msg_if.master         m,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;

    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              pop;
    logic              issue;
    logic              last_rd;
    logic              head_last;

    assign pop     = m.m_valid & m.m_ready;
    assign last_rd = (rem_q == (ADDR_W+1)'(1));

    // Slots committed after this cycle: buffered + arriving - leaving.
    assign occ = {1'b0, count} + (CW+1)'(infl_q) - (CW+1)'(pop);

    assign issue = (state_q == FETCH) && (rem_q != '0)
                 && (occ < (CW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (msg_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue && last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rom_en = issue;
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
    end

    always_comb begin
        addr_d      = addr_q;
        rem_d       = rem_q;
        infl_d      = issue;
        infl_last_d = issue && last_rd;
        if ((state_q == IDLE) && start) begin
            addr_d = start_addr;
            rem_d  = msg_len;
        end else if (issue) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - (ADDR_W+1)'(1);
        end
    end

    // A read still in flight is dropped on reset via infl_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    assign rom_addr = addr_q;

    byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl_q),
        .push_data (rom_data),
        .push_last (infl_last_q),
        .pop       (pop),
        .head_data (m.m_data),
        .head_last (head_last),
        .count     (count)
    );

    assign m.m_valid = (count != '0);
    assign m.m_last  = head_last;

endmodule

// File: doc/rom_msg_reader.md
# rom_msg_reader

Upstream sequencer for the 16x8 synchronous message ROM. On a start pulse it walks a message window (start address, length, wrapping at address 15) and drives the ROM's address/enable pins. It absorbs the ROM's one-cycle read latency and re-emits the bytes as a valid/ready byte stream with a last-byte flag. Reads are credit-limited so no byte is lost or duplicated under backpressure.

## Interface
- `ADDR_W`, default 4: ROM address width; message length field is `ADDR_W+1` bits.
- `DATA_W`, default 8: ROM/stream data width.
- `DEPTH`, default 2: output buffer entries; minimum 2.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: start request, sampled only in IDLE.
- `start_addr`  in  ADDR_W: first ROM address, captured with `start`.
- `msg_len`  in  ADDR_W+1: byte count, 0..16, captured with `start`.
- `rom_addr`  out  ADDR_W: ROM address.
- `rom_en`  out  1: ROM read enable.
- `rom_data`  in  DATA_W: ROM registered output, valid the cycle after `rom_en`.
- `m_data`  out  DATA_W: stream byte.
- `m_valid`  out  1: stream byte valid.
- `m_ready`  in  1: sink accepts.
- `m_last`  out  1: qualifies the final byte of the message.
- `busy`  out  1: message in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- States:
  - IDLE -> FETCH on `start` with `msg_len`>0.
  - IDLE -> DONE on `start` with `msg_len`=0.
  - FETCH -> DRAIN when the last read is issued.
  - DRAIN -> DONE when the last byte handshakes.
  - DONE -> IDLE unconditionally.
- Counters:
  - `remaining` is loaded with `msg_len` and decremented per issued read.
  - `inflight` is 0/1: a read issued last cycle.
  - `count` is the buffer occupancy.
- Read issue: `rom_en`=1 iff state is FETCH, `remaining`>0, and `count + inflight - pop < DEPTH`, where `pop` = `m_valid & m_ready`.
- Address handling: `rom_addr` increments after each issued read, modulo 2^ADDR_W (15 -> 0 wraps).
- Capture: when `inflight`=1, `rom_data` is pushed into the buffer that cycle, unconditionally. The credit rule guarantees room.
- Stream output:
  - `m_valid` = `count`>0; `m_data` is the buffer head.
  - `m_last` = 1 when the head is the final byte of the message.
- Output signals:
  - `busy` = state is not IDLE.
  - `done` = state is DONE.
- Ignored input: `start` in any state other than IDLE.
- `m_data` is held stable while `m_valid` is high and `m_ready` is low.
- Reset, including mid-message: state returns to IDLE and all counters and the buffer clear. A ROM byte still in flight is discarded.

## Timing
- Reset values: `rom_addr`=0, `rom_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0.
- `start` is sampled at edge 0. Then:
  - cycle 1: `rom_en`=1 with `rom_addr`=`start_addr`.
  - cycle 2: `rom_data` valid; it is pushed at the end of cycle 2.
  - cycle 3: first `m_valid`.
- Start-to-first-byte latency is 3 cycles.
- With `m_ready` held 1, throughput is 1 byte/cycle. For `msg_len`=N, the last byte appears in cycle N+2 and `done` pulses in cycle N+3.
- For `msg_len`=0, `done` pulses in cycle 1; `m_valid` and `rom_en` are never asserted.
- Push and pop in the same cycle leave `count` unchanged.

## Structure
- Shared package `rom_msg_pkg` holds:
  - `ADDR_W`, `DATA_W` defaults;
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - the ROM message constants for benches.
- Sub-module `byte_fifo`: synchronous DEPTH-entry FIFO with data plus last flag, push/pop, and count output. Reset is async active-low.
- The FSM, counters and credit logic stay in `rom_msg_reader`.

## Test plan
- Full message: `start_addr`=0, `msg_len`=16, `m_ready`=1. Bytes are 0x49,0x20,0x6C,0x6F,0x76,0x65,0x20,0x79,0x6F,0x75,0x20,0x64,0x75,0x64,0x65,0x21 in cycles 3..18. `m_last` is set only on 0x21; `done` pulses in cycle 19.
- Wrap: `start_addr`=14, `msg_len`=4 -> bytes 0x65,0x21,0x49,0x20; `rom_addr` sequence is 14,15,0,1.
- Backpressure: `msg_len`=8, `m_ready` toggling 1,0,0,1,... Exactly 8 bytes are delivered, in order, with no duplicates. `m_data` stays stable while stalled. `rom_en` is never asserted when `count + inflight - pop` = DEPTH.
- Zero length and ignored start:
  - `msg_len`=0 -> `done` in cycle 1, no `m_valid`.
  - `start` re-pulsed while busy -> no effect on the running message.
- Reset mid-message: `rst_n` low while `m_valid`=1 and stalled -> all outputs 0 immediately. After release the block is in IDLE, and a new start (addr 2, len 3) yields 0x6C,0x6F,0x76.
